// File: rtl/pipe_ctrl_unit_if.sv
// Pipeline control bus between the jump/stall sources and pipe_ctrl_unit.
//   jump_en_i   [NSRC]         per-source jump request, index 0 highest priority
//   jump_addr_i [NSRC*ADDR_W]  per-source jump target, source k at [k*ADDR_W +: ADDR_W]
//   stall_req_i [NSTAGE]       per-stage stall request
//   hold_req_i                 global hold (bus wait)
//   jump_en_o                  one-cycle jump pulse to the PC
//   jump_addr_o [ADDR_W]       jump target, valid with jump_en_o
//   flush_o     [NSTAGE]       per-stage flush
//   stall_o     [NSTAGE]       per-stage stall
//   busy_o                     controller not idle
// master: the side that drives requests (core / testbench); slave: pipe_ctrl_unit.
interface pipe_ctrl_unit_if #(
    parameter int ADDR_W = 32,
    parameter int NSRC   = 2,
    parameter int NSTAGE = 4
);
    logic [NSRC-1:0]        jump_en_i;
    logic [NSRC*ADDR_W-1:0] jump_addr_i;
    logic [NSTAGE-1:0]      stall_req_i;
    logic                   hold_req_i;
    logic                   jump_en_o;
    logic [ADDR_W-1:0]      jump_addr_o;
    logic [NSTAGE-1:0]      flush_o;
    logic [NSTAGE-1:0]      stall_o;
    logic                   busy_o;

    modport master (
        output jump_en_i, jump_addr_i, stall_req_i, hold_req_i,
        input  jump_en_o, jump_addr_o, flush_o, stall_o, busy_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, stall_req_i, hold_req_i,
        output jump_en_o, jump_addr_o, flush_o, stall_o, busy_o
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: arbitrates jump requests (lowest index wins), issues a
// registered one-cycle jump pulse, flushes all stages for FLUSH_LEN cycles after
// each jump, defers jump issue while hold_req_i is high, and generates per-stage
// stalls (a stalled stage also stalls every earlier stage; flush overrides stall).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pipe_ctrl_unit_if slave modport (requests in, jump/flush/stall/busy out)
module pipe_ctrl_unit #(
    parameter int ADDR_W    = 32,
    parameter int NSRC      = 2,
    parameter int NSTAGE    = 4,
    parameter int FLUSH_LEN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter is loaded with FLUSH_LEN-1 on the jump edge and counts down to 0,
    // giving exactly FLUSH_LEN cycles in FLUSH.
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_LEN - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              jen_q, jen_d;

    logic              sel_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic [NSTAGE-1:0] flush;
    logic [NSTAGE-1:0] stall;
    logic              stall_acc;

    // Fixed-priority select: first asserted source from index 0 upward.
    always_comb begin
        sel_vld  = 1'b0;
        sel_addr = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!sel_vld && bus.jump_en_i[i]) begin
                sel_vld  = 1'b1;
                sel_addr = bus.jump_addr_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            addr_q  <= '0;
            jen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            jen_q   <= jen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        jen_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    pend_d = sel_addr;
                    if (bus.hold_req_i) begin
                        state_d = PEND;
                    end else begin
                        jen_d   = 1'b1;
                        addr_d  = sel_addr;
                        cnt_d   = CNT_INIT;
                        state_d = FLUSH;
                    end
                end
            end
            PEND: begin
                if (!bus.hold_req_i) begin
                    jen_d   = 1'b1;
                    addr_d  = pend_q;
                    cnt_d   = CNT_INIT;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flush = (state_q == FLUSH) ? '1 : '0;

    // Walk from the last stage toward fetch, accumulating stall requests so a
    // stall at stage j reaches every stage k <= j; flush then masks the stall.
    always_comb begin
        stall     = '0;
        stall_acc = bus.hold_req_i;
        for (int unsigned j = 0; j < NSTAGE; j++) begin
            stall_acc                = stall_acc | bus.stall_req_i[NSTAGE-1-j];
            stall[NSTAGE-1-j]        = stall_acc & ~flush[NSTAGE-1-j];
        end
    end

    assign bus.jump_en_o   = jen_q;
    assign bus.jump_addr_o = addr_q;
    assign bus.flush_o     = flush;
    assign bus.stall_o     = stall;
    assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit (FLUSH_LEN=3). Expected jump targets
// are queued when an accepted jump is driven and popped by a monitor whenever
// jump_en_o pulses; directed checks cover flush/stall/busy/reset behaviour.
module tb_pipe_ctrl_unit;
    localparam int ADDR_W = 32;
    localparam int NSRC   = 2;
    localparam int NSTAGE = 4;
    localparam int FL     = 3;

    logic clk;
    logic rst_n;

    pipe_ctrl_unit_if #(.ADDR_W(ADDR_W), .NSRC(NSRC), .NSTAGE(NSTAGE)) bus ();

    pipe_ctrl_unit #(
        .ADDR_W(ADDR_W), .NSRC(NSRC), .NSTAGE(NSTAGE), .FLUSH_LEN(FL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    int unsigned   n_pushed = 0;
    int unsigned   n_pulses = 0;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_jump(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1);
        bus.jump_en_i   = en;
        bus.jump_addr_i = {a1, a0};
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back(a);
        n_pushed++;
    endtask

    // Scoreboard monitor: every jump pulse must match the oldest queued target.
    always begin
        @(posedge clk);
        #1;
        if (rst_n && bus.jump_en_o) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_pulse", {63'd0, bus.jump_en_o}, 64'd0);
            end else begin
                check_eq("jump_addr", {32'd0, bus.jump_addr_o}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        bus.hold_req_i  = 1'b0;
        bus.stall_req_i = 4'b0010;
        drive_jump(2'b00, 32'h0, 32'h0);

        // Reset state and combinational stall during reset
        step();
        step();
        check_eq("rst_jen",   {63'd0, bus.jump_en_o}, 64'd0);
        check_eq("rst_addr",  {32'd0, bus.jump_addr_o}, 64'd0);
        check_eq("rst_flush", {60'd0, bus.flush_o}, 64'd0);
        check_eq("rst_busy",  {63'd0, bus.busy_o}, 64'd0);
        check_eq("rst_stall", {60'd0, bus.stall_o}, 64'h3);
        rst_n           = 1'b1;
        bus.stall_req_i = 4'b0000;

        // Single jump
        drive_jump(2'b01, 32'h0000_1000, 32'h0);
        push_exp(32'h0000_1000);
        step();
        check_eq("s1_jen",   {63'd0, bus.jump_en_o}, 64'd1);
        check_eq("s1_flush", {60'd0, bus.flush_o}, 64'hF);
        check_eq("s1_busy",  {63'd0, bus.busy_o}, 64'd1);
        drive_jump(2'b00, 32'h0, 32'h0);
        step();
        check_eq("s1_pulse_one", {63'd0, bus.jump_en_o}, 64'd0);
        check_eq("s1_flush2", {60'd0, bus.flush_o}, 64'hF);
        step();
        check_eq("s1_flush3", {60'd0, bus.flush_o}, 64'hF);
        step();
        check_eq("s1_flush_end", {60'd0, bus.flush_o}, 64'h0);
        check_eq("s1_idle", {63'd0, bus.busy_o}, 64'd0);

        // Priority: both sources, source 0 wins
        drive_jump(2'b11, 32'h100, 32'h200);
        push_exp(32'h100);
        step();
        check_eq("s2_jen", {63'd0, bus.jump_en_o}, 64'd1);
        drive_jump(2'b00, 32'h0, 32'h0);
        repeat (FL) step();
        check_eq("s2_idle", {63'd0, bus.busy_o}, 64'd0);
        check_eq("s2_addr_hold", {32'd0, bus.jump_addr_o}, 64'h100);

        // Held jump: hold for 3 cycles, PEND ignores new requests
        bus.hold_req_i = 1'b1;
        drive_jump(2'b01, 32'h3000, 32'h0);
        push_exp(32'h3000);
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("s3_busy", {63'd0, bus.busy_o}, 64'd1);
            check_eq("s3_nopulse", {63'd0, bus.jump_en_o}, 64'd0);
            check_eq("s3_stall", {60'd0, bus.stall_o}, 64'hF);
            drive_jump(2'b10, 32'h0, 32'hDEAD);
        end
        bus.hold_req_i = 1'b0;
        drive_jump(2'b00, 32'h0, 32'h0);
        step();
        check_eq("s3_jen", {63'd0, bus.jump_en_o}, 64'd1);
        repeat (FL) step();
        check_eq("s3_idle", {63'd0, bus.busy_o}, 64'd0);

        // Stall propagation, then flush masking
        bus.stall_req_i = 4'b0100;
        #1;
        check_eq("s4_stall_0100", {60'd0, bus.stall_o}, 64'h7);
        bus.stall_req_i = 4'b1000;
        #1;
        check_eq("s4_stall_1000", {60'd0, bus.stall_o}, 64'hF);
        bus.stall_req_i = 4'b0001;
        #1;
        check_eq("s4_stall_0001", {60'd0, bus.stall_o}, 64'h1);
        bus.stall_req_i = 4'b0100;
        drive_jump(2'b01, 32'h4000, 32'h0);
        push_exp(32'h4000);
        step();
        check_eq("s4_stall_flush", {60'd0, bus.stall_o}, 64'h0);
        drive_jump(2'b00, 32'h0, 32'h0);
        repeat (FL) step();
        check_eq("s4_stall_after", {60'd0, bus.stall_o}, 64'h7);
        bus.stall_req_i = 4'b0000;

        // Requests during FLUSH are dropped; next accepted at FL+1 spacing
        drive_jump(2'b01, 32'h5000, 32'h0);
        push_exp(32'h5000);
        step();
        check_eq("s5_jen", {63'd0, bus.jump_en_o}, 64'd1);
        drive_jump(2'b01, 32'h6000, 32'h0);
        for (int c = 0; c < FL; c++) begin
            step();
            check_eq("s5_ignored", {63'd0, bus.jump_en_o}, 64'd0);
        end
        drive_jump(2'b10, 32'h0, 32'h7000);
        push_exp(32'h7000);
        step();
        check_eq("s5_spacing_jen", {63'd0, bus.jump_en_o}, 64'd1);
        drive_jump(2'b00, 32'h0, 32'h0);
        repeat (FL) step();
        check_eq("s5_idle", {63'd0, bus.busy_o}, 64'd0);

        // Reset mid-PEND; jump coincident with reset discarded
        bus.hold_req_i = 1'b1;
        drive_jump(2'b01, 32'h8000, 32'h0);
        step();
        check_eq("s6_pend_busy", {63'd0, bus.busy_o}, 64'd1);
        rst_n          = 1'b0;
        bus.hold_req_i = 1'b0;
        drive_jump(2'b01, 32'h9000, 32'h0);
        step();
        check_eq("s6_rst_busy", {63'd0, bus.busy_o}, 64'd0);
        check_eq("s6_rst_jen",  {63'd0, bus.jump_en_o}, 64'd0);
        check_eq("s6_rst_addr", {32'd0, bus.jump_addr_o}, 64'd0);
        rst_n = 1'b1;
        drive_jump(2'b00, 32'h0, 32'h0);
        step();
        check_eq("s6_post_jen",  {63'd0, bus.jump_en_o}, 64'd0);
        check_eq("s6_post_busy", {63'd0, bus.busy_o}, 64'd0);

        // Reset mid-FLUSH, then a normal jump
        drive_jump(2'b01, 32'hA000, 32'h0);
        push_exp(32'hA000);
        step();
        drive_jump(2'b00, 32'h0, 32'h0);
        rst_n = 1'b0;
        step();
        check_eq("s7_rst_flush", {60'd0, bus.flush_o}, 64'h0);
        check_eq("s7_rst_busy",  {63'd0, bus.busy_o}, 64'd0);
        check_eq("s7_rst_addr",  {32'd0, bus.jump_addr_o}, 64'd0);
        rst_n = 1'b1;
        drive_jump(2'b01, 32'hB000, 32'h0);
        push_exp(32'hB000);
        step();
        check_eq("s7_jen",   {63'd0, bus.jump_en_o}, 64'd1);
        check_eq("s7_flush", {60'd0, bus.flush_o}, 64'hF);
        drive_jump(2'b00, 32'h0, 32'h0);
        repeat (FL) step();
        check_eq("s7_idle", {63'd0, bus.busy_o}, 64'd0);

        step();
        check_eq("pulse_count", {32'd0, n_pulses}, {32'd0, n_pushed});
        check_eq("queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
